// File: rtl/stop_watch.sv
// ---------------------------------------------------------------------------
// stop_watch
//
// Purpose:
//   Front-panel stopwatch counting MM:SS.CC on a 100 Hz clock. Start/stop and
//   clear come from level push buttons; a press is the rising level of a
//   button, honoured only while the panel is in the stopwatch mode. Counting
//   itself runs regardless of the mode. Six active-low 7-segment digits are
//   driven directly from the registered counters.
//
// Configuration macro:
//   STOPWATCH_LEAD_BLANK_EN - when defined, the tens digit of minutes and of
//                             seconds is blanked while it is 0.
//
// Parameters:
//   STOPWATCH_MODE  value of currentMode in which the buttons act (default 2)
//
// Ports:
//   mili_clk     in   100 Hz clock, one hundredth of a second per edge
//   reset        in   synchronous active-low reset
//   currentMode  in   [1:0] global UI mode selector
//   mili_set     in   start/stop button (level, active-high)
//   mili_clear   in   clear button (level, active-high)
//   minutes      out  [5:0] binary minutes 0..59
//   seconds      out  [5:0] binary seconds 0..59
//   m_seconds    out  [6:0] binary hundredths 0..99
//   disp0..disp5 out  [6:0] segments {g,f,e,d,c,b,a}, active-low:
//                     minutes tens/units, seconds tens/units,
//                     hundredths tens/units
// ---------------------------------------------------------------------------

// Decimal digit to active-low 7-segment pattern; codes 10..15 are blank.
module seg_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

module stop_watch #(
  parameter logic [1:0] STOPWATCH_MODE = 2'd2
) (
  input  logic       mili_clk,
  input  logic       reset,
  input  logic [1:0] currentMode,
  input  logic       mili_set,
  input  logic       mili_clear,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [6:0] m_seconds,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic [6:0] disp3,
  output logic [6:0] disp4,
  output logic [6:0] disp5
);

  logic run;
  logic set_prev;
  logic clear_prev;
  logic mode_ok;
  logic set_press;
  logic clear_press;

  // Values are at most 99, so the quotient and remainder fit in 4 bits.
  function automatic logic [3:0] tens_of(input logic [6:0] v);
    logic [6:0] q;
    q = v / 7'd10;
    return q[3:0];
  endfunction

  function automatic logic [3:0] units_of(input logic [6:0] v);
    logic [6:0] r;
    r = v % 7'd10;
    return r[3:0];
  endfunction

  assign mode_ok     = (currentMode == STOPWATCH_MODE);
  assign set_press   = mode_ok & mili_set   & ~set_prev;
  assign clear_press = mode_ok & mili_clear & ~clear_prev;

  // Button history always tracks the raw levels, even outside the stopwatch
  // mode, so a button held across a mode change does not fire on entry.
  // A clear while stopped takes priority over a simultaneous set, leaving the
  // watch stopped at zero. Otherwise the increment uses the run value from
  // before this edge: a start press begins counting on the next edge, and a
  // stop press still counts on its own edge.
  always_ff @(posedge mili_clk) begin
    if (!reset) begin
      run        <= 1'b0;
      set_prev   <= 1'b0;
      clear_prev <= 1'b0;
      minutes    <= 6'd0;
      seconds    <= 6'd0;
      m_seconds  <= 7'd0;
    end else begin
      set_prev   <= mili_set;
      clear_prev <= mili_clear;
      if (clear_press && !run) begin
        minutes   <= 6'd0;
        seconds   <= 6'd0;
        m_seconds <= 7'd0;
      end else begin
        if (set_press) begin
          run <= ~run;
        end
        if (run) begin
          if (m_seconds == 7'd99) begin
            m_seconds <= 7'd0;
            if (seconds == 6'd59) begin
              seconds <= 6'd0;
              minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            end else begin
              seconds <= seconds + 6'd1;
            end
          end else begin
            m_seconds <= m_seconds + 7'd1;
          end
        end
      end
    end
  end

  logic [3:0] min_tens, min_units, sec_tens, sec_units, ms_tens, ms_units;
  logic [3:0] min_tens_disp, sec_tens_disp;

  assign min_tens  = tens_of({1'b0, minutes});
  assign min_units = units_of({1'b0, minutes});
  assign sec_tens  = tens_of({1'b0, seconds});
  assign sec_units = units_of({1'b0, seconds});
  assign ms_tens   = tens_of(m_seconds);
  assign ms_units  = units_of(m_seconds);

  // Code 10 decodes to a blank digit. Hundredths tens is never blanked.
`ifdef STOPWATCH_LEAD_BLANK_EN
  assign min_tens_disp = (min_tens == 4'd0) ? 4'd10 : min_tens;
  assign sec_tens_disp = (sec_tens == 4'd0) ? 4'd10 : sec_tens;
`else
  assign min_tens_disp = min_tens;
  assign sec_tens_disp = sec_tens;
`endif

  seg_decoder u_dec0 (.digit(min_tens_disp), .seg(disp0));
  seg_decoder u_dec1 (.digit(min_units),     .seg(disp1));
  seg_decoder u_dec2 (.digit(sec_tens_disp), .seg(disp2));
  seg_decoder u_dec3 (.digit(sec_units),     .seg(disp3));
  seg_decoder u_dec4 (.digit(ms_tens),       .seg(disp4));
  seg_decoder u_dec5 (.digit(ms_units),      .seg(disp5));

endmodule

// File: tb/tb_stop_watch.sv
// ---------------------------------------------------------------------------
// tb_stop_watch
//
// Self-checking bench for stop_watch. Expected counter values are pushed to
// a scoreboard queue as each cycle's stimulus is driven and popped after the
// edge. A short table of hand-computed vectors covers button semantics; a
// bench model (a single hundredths total) drives the long multi-cycle runs.
// ---------------------------------------------------------------------------
module tb_stop_watch;

  logic       mili_clk = 1'b0;
  logic       reset;
  logic [1:0] currentMode;
  logic       mili_set;
  logic       mili_clear;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [6:0] m_seconds;
  logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;
  logic [3:0] dec_digit;
  logic [6:0] dec_seg;

  // 100 Hz in spirit; the period here is arbitrary.
  always #5 mili_clk = ~mili_clk;

  stop_watch #(.STOPWATCH_MODE(2'd2)) dut (
    .mili_clk(mili_clk), .reset(reset), .currentMode(currentMode),
    .mili_set(mili_set), .mili_clear(mili_clear),
    .minutes(minutes), .seconds(seconds), .m_seconds(m_seconds),
    .disp0(disp0), .disp1(disp1), .disp2(disp2),
    .disp3(disp3), .disp4(disp4), .disp5(disp5)
  );

  // Stand-alone decoder instance so all 16 codes can be swept directly.
  seg_decoder dec (.digit(dec_digit), .seg(dec_seg));

  typedef struct {
    logic [5:0] mn;
    logic [5:0] sc;
    logic [6:0] ms;
  } exp_t;

  typedef struct {
    logic       rst_n;
    logic [1:0] mode;
    logic       set;
    logic       clr;
    logic [5:0] mn;
    logic [5:0] sc;
    logic [6:0] ms;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[17];
  logic [6:0] seg_ref[16];
  int         tests_run = 0;
  int         tests_failed = 0;

  // Bench model state
  bit m_run;
  int m_total;
  bit m_set_prev;
  bit m_clr_prev;

  task automatic checkVal(input string name, input int got, input int want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic logic [6:0] expSeg(input int d);
    return seg_ref[d];
  endfunction

  task automatic modelStep(input bit rst_n, input logic [1:0] mode,
                           input bit set, input bit clr);
    bit sp, cp;
    if (!rst_n) begin
      m_run = 0; m_total = 0; m_set_prev = 0; m_clr_prev = 0;
    end else begin
      sp = (mode == 2'd2) && set && !m_set_prev;
      cp = (mode == 2'd2) && clr && !m_clr_prev;
      m_set_prev = set;
      m_clr_prev = clr;
      if (cp && !m_run) begin
        m_total = 0;
      end else begin
        if (m_run) m_total = (m_total + 1) % 360000;
        if (sp) m_run = !m_run;
      end
    end
  endtask

  function automatic exp_t modelOut();
    exp_t e;
    e.mn = 6'(m_total / 6000);
    e.sc = 6'((m_total / 100) % 60);
    e.ms = 7'(m_total % 100);
    return e;
  endfunction

  task automatic checkOutput();
    exp_t e;
    int   mt, st;
    if (sb_q.size() == 0) begin
      checkVal("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    checkVal("minutes", minutes, e.mn);
    checkVal("seconds", seconds, e.sc);
    checkVal("m_seconds", m_seconds, e.ms);
    mt = e.mn / 10;
    st = e.sc / 10;
`ifdef STOPWATCH_LEAD_BLANK_EN
    if (mt == 0) mt = 10;
    if (st == 0) st = 10;
`endif
    checkVal("disp0", disp0, expSeg(mt));
    checkVal("disp1", disp1, expSeg(e.mn % 10));
    checkVal("disp2", disp2, expSeg(st));
    checkVal("disp3", disp3, expSeg(e.sc % 10));
    checkVal("disp4", disp4, expSeg(e.ms / 10));
    checkVal("disp5", disp5, expSeg(e.ms % 10));
  endtask

  // Drive one cycle's inputs away from the edge, queue its expectation,
  // then compare just after the edge.
  task automatic applyStimulus(input bit rst_n, input logic [1:0] mode,
                               input bit set, input bit clr, input exp_t e);
    @(negedge mili_clk);
    reset       = rst_n;
    currentMode = mode;
    mili_set    = set;
    mili_clear  = clr;
    sb_q.push_back(e);
    @(posedge mili_clk);
    #1;
    checkOutput();
  endtask

  task automatic step(input bit rst_n, input logic [1:0] mode,
                      input bit set, input bit clr);
    modelStep(rst_n, mode, set, clr);
    applyStimulus(rst_n, mode, set, clr, modelOut());
  endtask

  initial begin
    exp_t e;
    int   guard;

    seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

    // {rst_n, mode, set, clr, minutes, seconds, hundredths} after the edge
    vecs[0]  = '{1'b1, 2'd2, 1'b1, 1'b0, 6'd0, 6'd0, 7'd0}; // start
    vecs[1]  = '{1'b1, 2'd2, 1'b1, 1'b0, 6'd0, 6'd0, 7'd1}; // held: no toggle
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0, 7'd2};
    vecs[3]  = '{1'b1, 2'd2, 1'b0, 1'b1, 6'd0, 6'd0, 7'd3}; // clear ignored
    vecs[4]  = '{1'b1, 2'd0, 1'b1, 1'b0, 6'd0, 6'd0, 7'd4}; // wrong mode
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 1'b0, 6'd0, 6'd0, 7'd5};
    vecs[6]  = '{1'b1, 2'd2, 1'b1, 1'b0, 6'd0, 6'd0, 7'd6}; // stop counts once
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0, 7'd6};
    vecs[8]  = '{1'b1, 2'd2, 1'b1, 1'b1, 6'd0, 6'd0, 7'd0}; // clear wins
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0, 7'd0}; // still stopped
    vecs[10] = '{1'b1, 2'd2, 1'b1, 1'b0, 6'd0, 6'd0, 7'd0}; // start
    vecs[11] = '{1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0, 7'd1};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0, 7'd2};
    vecs[13] = '{1'b1, 2'd2, 1'b1, 1'b0, 6'd0, 6'd0, 7'd3}; // stop
    vecs[14] = '{1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0, 7'd3};
    vecs[15] = '{1'b1, 2'd2, 1'b0, 1'b1, 6'd0, 6'd0, 7'd0}; // clear stopped
    vecs[16] = '{1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0, 7'd0};

    reset = 1'b0; currentMode = 2'd0; mili_set = 1'b0; mili_clear = 1'b0;
    dec_digit = 4'd0;

    // Reset for two edges, then release.
    step(0, 2'd2, 0, 0);
    step(0, 2'd2, 0, 0);
    step(1, 2'd2, 0, 0);
    checkVal("reset_disp5", disp5, 7'b1000000);
`ifdef STOPWATCH_LEAD_BLANK_EN
    checkVal("reset_disp0", disp0, 7'b1111111);
`else
    checkVal("reset_disp0", disp0, 7'b1000000);
`endif

    // Table-driven button semantics; the model is stepped alongside.
    foreach (vecs[i]) begin
      modelStep(vecs[i].rst_n, vecs[i].mode, vecs[i].set, vecs[i].clr);
      e.mn = vecs[i].mn; e.sc = vecs[i].sc; e.ms = vecs[i].ms;
      applyStimulus(vecs[i].rst_n, vecs[i].mode, vecs[i].set, vecs[i].clr, e);
    end

    // Start, 149 idle edges, stop on the 150th: exactly 00:01.50.
    step(1, 2'd2, 1, 0);
    for (int i = 0; i < 149; i++) step(1, 2'd2, 0, 0);
    step(1, 2'd2, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 2'd2, 0, 0);
    checkVal("run150_seconds", seconds, 1);
    checkVal("run150_m_seconds", m_seconds, 50);

    // Clear while stopped, then run up to 00:59.99 and across the minute.
    step(1, 2'd2, 0, 1);
    step(1, 2'd2, 0, 0);
    checkVal("cleared_m_seconds", m_seconds, 0);
    step(1, 2'd2, 1, 0);
    guard = 0;
    while (m_total != 5999 && guard < 7000) begin
      step(1, 2'd2, 0, 0);
      guard++;
    end
    checkVal("edge_59_99_ms", m_seconds, 99);
    checkVal("edge_59_99_sec", seconds, 59);
    step(1, 2'd2, 0, 0);
    checkVal("minute_carry_min", minutes, 1);
    checkVal("minute_carry_sec", seconds, 0);
    checkVal("minute_carry_ms", m_seconds, 0);

    // Clear while running is ignored; mode 0 presses do nothing.
    step(1, 2'd2, 0, 1);
    step(1, 2'd2, 0, 0);
    step(1, 2'd0, 1, 1);
    step(1, 2'd0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 2'd0, 0, 0);
    checkVal("mode0_still_running", m_seconds, 7);

    // Holding set for 10 edges toggles once (stops), then stays frozen.
    for (int i = 0; i < 10; i++) step(1, 2'd2, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 2'd2, 0, 0);

    // Restart and reset mid-run.
    step(1, 2'd2, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 2'd2, 0, 0);
    step(0, 2'd2, 0, 0);
    checkVal("midrun_reset_ms", m_seconds, 0);
    for (int i = 0; i < 3; i++) step(1, 2'd2, 0, 0);

    // Decoder sweep over all 16 codes.
    for (int d = 0; d < 16; d++) begin
      dec_digit = 4'(d);
      #1;
      checkVal($sformatf("decoder_%0d", d), dec_seg, seg_ref[d]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
